peripheral_timer: RTL and testbench
===================================

# peripheral_timer

Memory-mapped timer peripheral on the MIPS monocycle peripheral bus, downstream of the peripheral address decoder. It consumes the decoder's timer chip-enable, read/write strobe and 4-bit register select, and holds a prescaled up-counter with compare match, optional auto-reload and a level interrupt toward the PIC. Reads are combinational so the single-cycle core gets data in the same cycle; writes commit on the rising clock edge.

## Interface
- COUNT_WIDTH, 32: counter and compare width, 1..32; registers zero-extend to 32 bits on read.
- PRESCALE_WIDTH, 8: width of prescaler field and counter.
- clk  in  1  single system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- ce  in  1  timer select from decoder (ce_out bit 1).
- rw  in  1  1 = write, 0 = read; ignored when ce = 0.
- reg_sel  in  4  register select, address bits [11:8].
- data_in  in  32  CPU write data.
- data_out  out  32  read data; 0 when ce = 0 or rw = 1.
- irq  out  1  level interrupt to PIC.

## Operation
- Registers:
  - 0x0 CTRL: [0] EN, [1] AUTO (auto-reload), [2] IE (interrupt enable), [15:8] PRESCALE. Other bits read 0.
  - 0x1 COUNT.
  - 0x2 COMPARE.
  - 0x3 STATUS: [0] MATCH, write-1-to-clear.
  - 0x4–0xF read 0; writes ignored.
- Prescaler counts 0..PRESCALE while EN = 1 and emits a 1-cycle tick when it equals PRESCALE, then returns to 0. With PRESCALE = 0, tick fires every cycle. EN = 0 holds prescaler at 0.
- On tick:
  - If COUNT == COMPARE: set MATCH. If AUTO = 1, COUNT <= 0. If AUTO = 0, COUNT holds and EN <= 0 (one-shot stop).
  - Otherwise COUNT <= COUNT + 1, wrapping modulo 2^COUNT_WIDTH with no flag.
- irq = MATCH & IE, combinational from registers.
- State: IDLE (EN = 0), RUN (EN = 1), DONE (one-shot matched: EN = 0, MATCH = 1).
  - Transitions are implicit from the register values.
  - A CPU write of EN = 1 from DONE re-enters RUN without clearing COUNT.
- Writes to COUNT/COMPARE truncate data_in to COUNT_WIDTH. Writes to COUNT or CTRL reset the prescaler to 0.

## Timing
- Reset values: CTRL = 0, COUNT = 0, COMPARE = all ones, MATCH = 0, prescaler = 0. Consequently irq = 0 and data_out = 0.
- Write: value is visible on data_out at the first read after the edge where ce & rw is sampled.
- Read latency: 0 cycles (combinational).
- Count latency: the first tick occurs PRESCALE+1 cycles after the EN write edge.
- MATCH, and irq when IE = 1, rise at the edge of the matching tick.
- Simultaneous events:
  - CPU write to COUNT vs tick increment/reload: CPU write wins; tick is discarded and MATCH is not set that cycle.
  - CPU write to CTRL.EN = 1 vs one-shot auto-clear of EN on the same edge: CPU write wins.
  - STATUS clear vs new match on the same edge: set wins, so MATCH stays 1.
  - Change of COMPARE takes effect on the next tick.
- rst_n asserted mid-count: all state returns to reset values asynchronously; irq drops immediately.

## Configuration
- PERIPHERAL_TIMER_PRESCALER_EN defined: prescaler present as described; CTRL[15:8] is read/write.
- Not defined: no prescaler logic; tick = EN every cycle; CTRL[15:8] reads 0 and writes are ignored.

## Structure
- Shared package peripheral_pkg holds:
  - register offsets TIMER_REG_CTRL/COUNT/COMPARE/STATUS;
  - CTRL bit positions (EN, AUTO, IE, PRESCALE LSB/MSB);
  - STATUS_MATCH bit;
  - rw encoding constants.
- Sub-module timer_prescaler (inputs: clk, rst_n, enable, clear, prescale value; output: tick). It is instantiated only under PERIPHERAL_TIMER_PRESCALER_EN.

## Test plan
- Reset: rst_n low mid-run with COUNT = 5 -> COUNT = 0, COMPARE = 0xFFFFFFFF, irq = 0 asynchronously.
- PRESCALE = 0, COMPARE = 3, AUTO = 1, IE = 1, EN = 1 -> COUNT 1,2,3 on successive cycles, MATCH/irq set, COUNT = 0 the next cycle; write STATUS = 1 -> irq = 0.
- PRESCALE = 4, COMPARE = 2, AUTO = 0 -> COUNT increments every 5 cycles; match at COUNT = 2; EN reads 0; COUNT holds at 2.
- Write COUNT = 0x10 on the same edge as a tick -> COUNT reads 0x10, not 0x11 and not reloaded.
- STATUS clear on the same edge as a new match -> MATCH stays 1.
- Read reg_sel 0x7 and read with ce = 0 -> data_out = 0; macro undefined: write CTRL = 0x0000FF01 -> reads 0x00000001 and counts every cycle.

Source files
------------

// File: rtl/peripheral_pkg.sv
// Shared register map and bit positions for the peripheral bus blocks.
// Latency: n/a (constants only).
// Backpressure: n/a; the peripheral bus has no stall, so every access completes in one cycle.
package peripheral_pkg;

  // Timer register offsets (address bits [11:8])
  localparam logic [3:0] TIMER_REG_CTRL    = 4'h0;
  localparam logic [3:0] TIMER_REG_COUNT   = 4'h1;
  localparam logic [3:0] TIMER_REG_COMPARE = 4'h2;
  localparam logic [3:0] TIMER_REG_STATUS  = 4'h3;

  // CTRL bit positions
  localparam int CTRL_EN_BIT       = 0;
  localparam int CTRL_AUTO_BIT     = 1;
  localparam int CTRL_IE_BIT       = 2;
  localparam int CTRL_PRESCALE_LSB = 8;
  localparam int CTRL_PRESCALE_MSB = 15;

  // STATUS bit positions
  localparam int STATUS_MATCH_BIT  = 0;

  // Bus direction encoding
  localparam logic RW_READ  = 1'b0;
  localparam logic RW_WRITE = 1'b1;

endpackage

// File: rtl/timer_prescaler.sv
// Prescaler for peripheral_timer: counts 0..prescale and pulses tick on the terminal value.
// Latency: tick is combinational from the internal count; the first tick comes prescale+1 cycles after enable rises.
// Backpressure: none; tick is a single-cycle pulse that the consumer must take.
//
// Ports:
//   clk, rst_n  clock, async active-low reset
//   enable      run the prescaler; low holds the count at 0
//   clear       force the count back to 0 on the next edge
//   prescale    terminal count
//   tick        high in the cycle the count equals prescale
module timer_prescaler #(
  parameter int PRESCALE_WIDTH = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      enable,
  input  logic                      clear,
  input  logic [PRESCALE_WIDTH-1:0] prescale,
  output logic                      tick
);

  logic [PRESCALE_WIDTH-1:0] cnt;
  logic                      at_end;

  assign at_end = (cnt == prescale);
  assign tick   = enable & at_end;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clear || !enable || at_end) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/peripheral_timer.sv
// Memory-mapped prescaled up-counter with compare match, optional auto-reload and level irq.
// Latency: reads are combinational (0 cycles); writes and count updates commit on the rising edge.
// Backpressure: none; every bus access completes in the cycle it is presented.
//
// Ports:
//   clk, rst_n  clock, async active-low reset
//   ce          timer chip-enable from the peripheral decoder
//   rw          1 = write, 0 = read (ignored when ce = 0)
//   reg_sel     register select: 0 CTRL, 1 COUNT, 2 COMPARE, 3 STATUS, others read 0
//   data_in     CPU write data
//   data_out    read data, 0 unless ce & ~rw
//   irq         MATCH & IE, level
//
// Build option: PERIPHERAL_TIMER_PRESCALER_EN adds the prescaler and makes CTRL[15:8]
// read/write; without it the counter ticks every cycle while EN is set.
module peripheral_timer
  import peripheral_pkg::*;
#(
  parameter int COUNT_WIDTH    = 32,
  parameter int PRESCALE_WIDTH = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ce,
  input  logic        rw,
  input  logic [3:0]  reg_sel,
  input  logic [31:0] data_in,
  output logic [31:0] data_out,
  output logic        irq
);

  logic                   ctrl_en;
  logic                   ctrl_auto;
  logic                   ctrl_ie;
  logic [COUNT_WIDTH-1:0] count;
  logic [COUNT_WIDTH-1:0] compare;
  logic                   match;
  logic                   tick;

  logic wr;
  logic wr_ctrl;
  logic wr_count;
  logic wr_compare;
  logic wr_status;
  logic hit;

  assign wr         = ce & (rw == RW_WRITE);
  assign wr_ctrl    = wr & (reg_sel == TIMER_REG_CTRL);
  assign wr_count   = wr & (reg_sel == TIMER_REG_COUNT);
  assign wr_compare = wr & (reg_sel == TIMER_REG_COMPARE);
  assign wr_status  = wr & (reg_sel == TIMER_REG_STATUS);

  // A CPU write to COUNT swallows the tick entirely, so no match can be raised on that edge.
  assign hit = tick & ~wr_count & (count == compare);

`ifdef PERIPHERAL_TIMER_PRESCALER_EN
  logic [PRESCALE_WIDTH-1:0] ctrl_prescale;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctrl_prescale <= '0;
    end else if (wr_ctrl) begin
      ctrl_prescale <= data_in[CTRL_PRESCALE_LSB +: PRESCALE_WIDTH];
    end
  end

  // Restarting the prescale period on COUNT/CTRL writes keeps the first tick a full period away.
  timer_prescaler #(
    .PRESCALE_WIDTH(PRESCALE_WIDTH)
  ) u_prescaler (
    .clk      (clk),
    .rst_n    (rst_n),
    .enable   (ctrl_en),
    .clear    (wr_ctrl | wr_count),
    .prescale (ctrl_prescale),
    .tick     (tick)
  );
`else
  assign tick = ctrl_en;
`endif

  // CTRL: a CPU write of EN beats the one-shot stop landing on the same edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctrl_en   <= 1'b0;
      ctrl_auto <= 1'b0;
      ctrl_ie   <= 1'b0;
    end else if (wr_ctrl) begin
      ctrl_en   <= data_in[CTRL_EN_BIT];
      ctrl_auto <= data_in[CTRL_AUTO_BIT];
      ctrl_ie   <= data_in[CTRL_IE_BIT];
    end else if (hit && !ctrl_auto) begin
      ctrl_en   <= 1'b0;
    end
  end

  // COUNT: reload on match when AUTO, hold on one-shot match, otherwise wrap-increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (wr_count) begin
      count <= data_in[COUNT_WIDTH-1:0];
    end else if (hit) begin
      if (ctrl_auto) begin
        count <= '0;
      end
    end else if (tick) begin
      count <= count + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      compare <= '1;
    end else if (wr_compare) begin
      compare <= data_in[COUNT_WIDTH-1:0];
    end
  end

  // MATCH: set dominates a write-1-to-clear on the same edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      match <= 1'b0;
    end else begin
      match <= hit | (match & ~(wr_status & data_in[STATUS_MATCH_BIT]));
    end
  end

  assign irq = match & ctrl_ie;

  always_comb begin
    data_out = '0;
    if (ce && (rw == RW_READ)) begin
      case (reg_sel)
        TIMER_REG_CTRL: begin
          data_out[CTRL_EN_BIT]   = ctrl_en;
          data_out[CTRL_AUTO_BIT] = ctrl_auto;
          data_out[CTRL_IE_BIT]   = ctrl_ie;
`ifdef PERIPHERAL_TIMER_PRESCALER_EN
          data_out[CTRL_PRESCALE_LSB +: PRESCALE_WIDTH] = ctrl_prescale;
`endif
        end
        TIMER_REG_COUNT:   data_out[COUNT_WIDTH-1:0] = count;
        TIMER_REG_COMPARE: data_out[COUNT_WIDTH-1:0] = compare;
        TIMER_REG_STATUS:  data_out[STATUS_MATCH_BIT] = match;
        default:           data_out = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_peripheral_timer.sv
// Directed bench for peripheral_timer: register access, counting, match, reload, one-shot and collisions.
// Latency: n/a.
// Backpressure: n/a.
module tb_peripheral_timer;

  logic        clk;
  logic        rst_n;
  logic        ce;
  logic        rw;
  logic [3:0]  reg_sel;
  logic [31:0] data_in;
  logic [31:0] data_out;
  logic        irq;

  int total;
  int bad;

  peripheral_timer #(
    .COUNT_WIDTH    (32),
    .PRESCALE_WIDTH (8)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .ce       (ce),
    .rw       (rw),
    .reg_sel  (reg_sel),
    .data_in  (data_in),
    .data_out (data_out),
    .irq      (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // All tasks start and end 1 ns after a rising edge.
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic bus_write(input logic [3:0] sel, input logic [31:0] dat);
    ce      = 1'b1;
    rw      = 1'b1;
    reg_sel = sel;
    data_in = dat;
    @(posedge clk);
    #1;
    ce      = 1'b0;
    rw      = 1'b0;
    data_in = '0;
  endtask

  task automatic bus_read(input logic [3:0] sel, output logic [31:0] dat);
    ce      = 1'b1;
    rw      = 1'b0;
    reg_sel = sel;
    #1;
    dat     = data_out;
    ce      = 1'b0;
  endtask

  logic [31:0] rd;

  initial begin
    total   = 0;
    bad     = 0;
    rst_n   = 1'b0;
    ce      = 1'b0;
    rw      = 1'b0;
    reg_sel = '0;
    data_in = '0;

    // Reset state
    #12;
    check("rst_irq", {31'd0, irq}, 32'd0);
    check("rst_dout", data_out, 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    bus_read(4'h0, rd); check("rst_ctrl", rd, 32'd0);
    bus_read(4'h1, rd); check("rst_count", rd, 32'd0);
    bus_read(4'h2, rd); check("rst_compare", rd, 32'hFFFF_FFFF);
    bus_read(4'h3, rd); check("rst_status", rd, 32'd0);

    // PRESCALE = 0, COMPARE = 3, AUTO/IE/EN
    bus_write(4'h2, 32'd3);
    bus_write(4'h0, 32'h0000_0007);
    bus_read(4'h1, rd); check("ps0_cnt0", rd, 32'd0);
    step(1); bus_read(4'h1, rd); check("ps0_cnt1", rd, 32'd1);
    step(1); bus_read(4'h1, rd); check("ps0_cnt2", rd, 32'd2);
    step(1); bus_read(4'h1, rd); check("ps0_cnt3", rd, 32'd3);
    check("ps0_irq_pre", {31'd0, irq}, 32'd0);
    step(1); bus_read(4'h1, rd); check("ps0_reload", rd, 32'd0);
    check("ps0_irq", {31'd0, irq}, 32'd1);
    bus_read(4'h3, rd); check("ps0_match", rd, 32'd1);
    bus_write(4'h3, 32'd1);
    check("ps0_irq_clr", {31'd0, irq}, 32'd0);
    bus_write(4'h0, 32'd0);

    // One-shot match at COUNT = COMPARE = 5, then async reset mid-cycle
    bus_write(4'h2, 32'd5);
    bus_write(4'h1, 32'd5);
    bus_write(4'h0, 32'h0000_0005);
    step(1);
    check("os_irq", {31'd0, irq}, 32'd1);
    bus_read(4'h0, rd); check("os_en_off", rd, 32'h0000_0004);
    step(2);
    bus_read(4'h1, rd); check("os_hold", rd, 32'd5);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_irq", {31'd0, irq}, 32'd0);
    bus_read(4'h1, rd); check("arst_count", rd, 32'd0);
    bus_read(4'h2, rd); check("arst_compare", rd, 32'hFFFF_FFFF);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

`ifdef PERIPHERAL_TIMER_PRESCALER_EN
    // PRESCALE = 4, COMPARE = 2, one-shot
    bus_write(4'h2, 32'd2);
    bus_write(4'h0, 32'h0000_0401);
    step(4); bus_read(4'h1, rd); check("ps4_e4", rd, 32'd0);
    step(1); bus_read(4'h1, rd); check("ps4_e5", rd, 32'd1);
    step(4); bus_read(4'h1, rd); check("ps4_e9", rd, 32'd1);
    step(1); bus_read(4'h1, rd); check("ps4_e10", rd, 32'd2);
    bus_read(4'h3, rd); check("ps4_nomatch", rd, 32'd0);
    step(5); bus_read(4'h3, rd); check("ps4_match", rd, 32'd1);
    bus_read(4'h0, rd); check("ps4_en_off", rd, 32'h0000_0400);
    step(5); bus_read(4'h1, rd); check("ps4_hold", rd, 32'd2);
    bus_write(4'h3, 32'd1);
    bus_write(4'h0, 32'h0000_FF01);
    bus_read(4'h0, rd); check("ctrl_ps_rw", rd, 32'h0000_FF01);
    step(3); bus_read(4'h1, rd); check("ps255_slow", rd, 32'd2);
    bus_write(4'h0, 32'd0);
    bus_write(4'h1, 32'd0);
`else
    // No prescaler: PRESCALE field is dropped and the counter runs every cycle
    bus_write(4'h0, 32'h0000_FF01);
    bus_read(4'h0, rd); check("ctrl_ps_drop", rd, 32'h0000_0001);
    step(3); bus_read(4'h1, rd); check("nops_cnt3", rd, 32'd3);
    bus_write(4'h0, 32'd0);
    bus_write(4'h1, 32'd0);
`endif

    // COUNT write collides with a tick that would also match/reload
    bus_write(4'h2, 32'h20);
    bus_write(4'h1, 32'h20);
    bus_write(4'h0, 32'h0000_0007);
    bus_write(4'h1, 32'h10);
    bus_read(4'h1, rd); check("wr_vs_tick", rd, 32'h10);
    bus_read(4'h3, rd); check("wr_vs_tick_nomatch", rd, 32'd0);
    step(1); bus_read(4'h1, rd); check("after_wr_inc", rd, 32'h11);

    // STATUS clear on the same edge as a new match
    bus_write(4'h2, 32'h13);
    bus_read(4'h1, rd); check("coll_cnt12", rd, 32'h12);
    step(1);
    bus_write(4'h3, 32'd1);
    bus_read(4'h3, rd); check("set_beats_clr", rd, 32'd1);
    check("set_beats_clr_irq", {31'd0, irq}, 32'd1);
    bus_read(4'h1, rd); check("coll_reload", rd, 32'd0);
    bus_write(4'h3, 32'd1);
    bus_read(4'h3, rd); check("w1c", rd, 32'd0);

    // Read gating
    reg_sel = 4'h0;
    rw      = 1'b0;
    ce      = 1'b0;
    #1;
    check("ce_low", data_out, 32'd0);
    ce      = 1'b1;
    rw      = 1'b1;
    reg_sel = 4'h7;
    data_in = 32'hDEAD_BEEF;
    #1;
    check("rw_high", data_out, 32'd0);
    ce      = 1'b0;
    rw      = 1'b0;
    data_in = '0;
    step(1);
    bus_read(4'h7, rd); check("sel7", rd, 32'd0);
    bus_write(4'h0, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
